kamikaze_decode: RTL and testbench
==================================

Name: kamikaze_decode

Overview:
Decode stage directly downstream of kamikaze_fetch. Consumes the fetched instruction word, PC and compressed flag, and produces a registered, field-decoded instruction for the execute stage. It also drives the register-file read addresses. It detects load-use hazards, inserts one bubble and back-pressures fetch through its stall input. The instruction word is always the 32-bit equivalent; the compressed flag only changes the PC increment.

Parameters:
- RESET_PC, 32'h0000_0000, value of d_pc_o/d_pc_next_o at reset.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- f_valid_i  in  1  fetch output valid
- f_ir_i  in  32  fetched instruction, 32-bit form
- f_pc_i  in  32  PC of f_ir_i
- f_is_compressed_i  in  1  instruction originated as 16-bit RVC
- f_stall_o  out  1  stall request to fetch (drives fetch f_stall_i)
- d_stall_i  in  1  execute cannot accept; hold stage
- d_kill_i  in  1  flush (taken branch/trap); dominates stall
- rf_rs1_o  out  5  register-file read address 1 (combinational)
- rf_rs2_o  out  5  register-file read address 2 (combinational)
- d_valid_o  out  1  decoded instruction valid
- d_ir_o  out  32  raw instruction
- d_pc_o  out  32  instruction PC
- d_pc_next_o  out  32  d_pc_o + 2 (compressed) or + 4
- d_opcode_o  out  5  ir[6:2]
- d_fun3_o  out  3  ir[14:12]
- d_fun7_o  out  7  ir[31:25]
- d_rs1_o, d_rs2_o, d_rd_o  out  5 each  register indices
- d_imm_o  out  32  sign-extended immediate for the format
- d_rd_we_o  out  1  instruction writes rd and rd != 0
- d_is_load_o, d_is_store_o, d_is_branch_o, d_is_jal_o, d_is_jalr_o, d_is_system_o  out  1 each  class flags
- d_illegal_o  out  1  unknown opcode or ir[1:0] != 2'b11

Behaviour:
- Reset (rst_i low, async): all outputs 0, except d_pc_o = RESET_PC and d_pc_next_o = RESET_PC + 4. No pending hazard.
- Latency: 1 cycle from accepted f_* inputs to d_* outputs.
- Hazard (combinational): d_valid_o && d_is_load_o && d_rd_o != 0 && f_valid_i && the incoming instruction uses rs1 (or rs2) and that index == d_rd_o.
  - rs1 is used by all classes except LUI, AUIPC and JAL.
  - rs2 is used by BRANCH, STORE and OP.
- f_stall_o = d_stall_i || (hazard && !d_kill_i).
- Register update per rising edge, in priority order:
  1. d_kill_i: d_valid_o <= 0; other fields don't-care but held.
  2. d_stall_i: hold all outputs.
  3. hazard: d_valid_o <= 0 (bubble); fetch is held by f_stall_o, so the same instruction is offered again next cycle.
  4. Otherwise: load from f_*; d_valid_o <= f_valid_i.
- A bubble is one cycle. Execute forwards the load result from writeback thereafter.
- rf_rs1_o / rf_rs2_o:
  - When the stage advances (case 4): f_ir_i[19:15] / f_ir_i[24:20].
  - Otherwise: d_rs1_o / d_rs2_o. This keeps sync-read register-file data aligned with the d_* outputs.
- Immediates (bit slices of ir, sign bit ir[31]):
  - I: LOAD, OP-IMM, JALR, SYSTEM
  - S: STORE
  - B: BRANCH, bit 0 = 0
  - U: LUI, AUIPC, low 12 bits 0
  - J: JAL, bit 0 = 0
  - OP and MISC-MEM: 0
- d_rd_we_o = (LUI | AUIPC | JAL | JALR | LOAD | OP-IMM | OP | SYSTEM) && rd != 0 && !illegal.
- Illegal instructions are still passed with d_valid_o = 1 and d_illegal_o = 1; execute raises the trap. All class flags are 0 in that case.
- Valid opcodes (ir[6:0]):
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111
  - BRANCH 1100011, LOAD 0000011, STORE 0100011
  - OP-IMM 0010011, OP 0110011, MISC-MEM 0001111, SYSTEM 1110011
- d_pc_next_o is computed with 32-bit wrap: 0xFFFF_FFFE + 2 = 0x0000_0000.
- Kill together with hazard: the kill wins and no stall is issued, so fetch is redirected. Kill together with stall: the kill wins and d_valid_o clears.

Decomposition:
- Shared header kamikaze_defs: opcode constants and the immediate-format enum, also used by the execute stage.
- One combinational sub-module, kamikaze_imm_decode (ir in, imm and format out). The rest stays in kamikaze_decode: pipeline register, hazard logic, class decode.

Test Plan:
- ADDI x1,x2,-5 (0xFFB10093), PC 0x100, uncompressed, no stalls -> next cycle d_valid_o=1, d_rs1_o=2, d_rd_o=1, d_imm_o=0xFFFF_FFFB, d_rd_we_o=1, d_pc_next_o=0x104; rf_rs1_o=2 in the cycle it is presented.
- LW x5,0(x6) (0x00032283) followed by ADD x7,x5,x1 (0x001283B3) -> one cycle with f_stall_o=1 and a bubble (d_valid_o=0), then the ADD appears with d_rs1_o=5 and d_rs2_o=1; exactly one lost cycle.
- The same LW/ADD pair with d_kill_i=1 during the hazard cycle -> f_stall_o=0, d_valid_o=0 next cycle, and no bubble persists afterwards.
- Compressed instruction at PC 0x200 (f_is_compressed_i=1) -> d_pc_next_o=0x202; with PC 0xFFFF_FFFE -> 0x0000_0000.
- f_ir_i=0x0000_0000 -> d_valid_o=1, d_illegal_o=1, d_rd_we_o=0, all class flags 0.
- d_stall_i=1 for 3 cycles while new f_* values change -> d_* outputs and rf_rs*_o stay frozen and f_stall_o=1; assert rst_i low mid-stall -> outputs go to reset values immediately.

Source files
------------

// File: rtl/kamikaze_defs_pkg.sv
// Shared decode definitions: RV32 opcode constants and the immediate-format
// enum, used by both the decode and execute stages.
package kamikaze_defs_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_t;

  // Full 7-bit compare, so any word with ir[1:0] != 2'b11 is unknown too.
  function automatic logic opcode_known(input logic [6:0] op);
    case (op)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: opcode_known = 1'b1;
      default: opcode_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/kamikaze_imm_decode.sv
// Combinational immediate extraction: selects the RV32 immediate format from
// the opcode and assembles the sign-extended immediate.
module kamikaze_imm_decode
  import kamikaze_defs_pkg::*;
(
  input  logic [31:0] ir,
  output logic [31:0] imm,
  output imm_fmt_t    fmt
);

  always_comb begin
    fmt = IMM_NONE;
    case (ir[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
      OPC_STORE:                                  fmt = IMM_S;
      OPC_BRANCH:                                 fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
      OPC_JAL:                                    fmt = IMM_J;
      default:                                    fmt = IMM_NONE;
    endcase
  end

  // OP, MISC-MEM and unknown opcodes carry no immediate and yield zero.
  always_comb begin
    imm = 32'd0;
    case (fmt)
      IMM_I:   imm = {{20{ir[31]}}, ir[31:20]};
      IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   imm = {ir[31:12], 12'd0};
      IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/kamikaze_decode.sv
// Decode stage: registers a field-decoded instruction for execute, drives the
// register-file read addresses and inserts a one-cycle bubble on load-use.
module kamikaze_decode
  import kamikaze_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        f_valid_i,
  input  logic [31:0] f_ir_i,
  input  logic [31:0] f_pc_i,
  input  logic        f_is_compressed_i,
  output logic        f_stall_o,
  input  logic        d_stall_i,
  input  logic        d_kill_i,
  output logic [4:0]  rf_rs1_o,
  output logic [4:0]  rf_rs2_o,
  output logic        d_valid_o,
  output logic [31:0] d_ir_o,
  output logic [31:0] d_pc_o,
  output logic [31:0] d_pc_next_o,
  output logic [4:0]  d_opcode_o,
  output logic [2:0]  d_fun3_o,
  output logic [6:0]  d_fun7_o,
  output logic [4:0]  d_rs1_o,
  output logic [4:0]  d_rs2_o,
  output logic [4:0]  d_rd_o,
  output logic [31:0] d_imm_o,
  output logic        d_rd_we_o,
  output logic        d_is_load_o,
  output logic        d_is_store_o,
  output logic        d_is_branch_o,
  output logic        d_is_jal_o,
  output logic        d_is_jalr_o,
  output logic        d_is_system_o,
  output logic        d_illegal_o
);

  logic [6:0]  op;
  logic [4:0]  f_rs1;
  logic [4:0]  f_rs2;
  logic [4:0]  f_rd;
  logic [31:0] f_imm;
  imm_fmt_t    f_fmt;
  logic        f_illegal;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_op_imm, is_op, is_system;
  logic        f_rd_we;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic        advance;
  logic [31:0] f_pc_next;

  assign op    = f_ir_i[6:0];
  assign f_rs1 = f_ir_i[19:15];
  assign f_rs2 = f_ir_i[24:20];
  assign f_rd  = f_ir_i[11:7];

  kamikaze_imm_decode u_imm (
    .ir  (f_ir_i),
    .imm (f_imm),
    .fmt (f_fmt)
  );

  // Unknown opcodes match none of the compares, so their class flags stay 0.
  always_comb begin
    is_lui    = (op == OPC_LUI);
    is_auipc  = (op == OPC_AUIPC);
    is_jal    = (op == OPC_JAL);
    is_jalr   = (op == OPC_JALR);
    is_branch = (op == OPC_BRANCH);
    is_load   = (op == OPC_LOAD);
    is_store  = (op == OPC_STORE);
    is_op_imm = (op == OPC_OP_IMM);
    is_op     = (op == OPC_OP);
    is_system = (op == OPC_SYSTEM);
    f_illegal = !opcode_known(op);
    f_rd_we   = (is_lui | is_auipc | is_jal | is_jalr | is_load |
                 is_op_imm | is_op | is_system) && (f_rd != 5'd0);
  end

  // U- and J-format instructions (LUI, AUIPC, JAL) are the only ones without rs1.
  always_comb begin
    uses_rs1 = !f_illegal && (f_fmt != IMM_U) && (f_fmt != IMM_J);
    uses_rs2 = (f_fmt == IMM_S) || (f_fmt == IMM_B) || is_op;
    hazard   = d_valid_o && d_is_load_o && (d_rd_o != 5'd0) && f_valid_i &&
               ((uses_rs1 && (f_rs1 == d_rd_o)) || (uses_rs2 && (f_rs2 == d_rd_o)));
    advance  = !d_kill_i && !d_stall_i && !hazard;
  end

  assign f_stall_o = d_stall_i || (hazard && !d_kill_i);
  assign f_pc_next = f_pc_i + (f_is_compressed_i ? 32'd2 : 32'd4);

  // Read addresses follow the register that will hold the instruction next
  // cycle, keeping sync-read register-file data aligned with the d_* outputs.
  assign rf_rs1_o = advance ? f_rs1 : d_rs1_o;
  assign rf_rs2_o = advance ? f_rs2 : d_rs2_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      d_valid_o     <= 1'b0;
      d_ir_o        <= 32'd0;
      d_pc_o        <= RESET_PC;
      d_pc_next_o   <= RESET_PC + 32'd4;
      d_opcode_o    <= 5'd0;
      d_fun3_o      <= 3'd0;
      d_fun7_o      <= 7'd0;
      d_rs1_o       <= 5'd0;
      d_rs2_o       <= 5'd0;
      d_rd_o        <= 5'd0;
      d_imm_o       <= 32'd0;
      d_rd_we_o     <= 1'b0;
      d_is_load_o   <= 1'b0;
      d_is_store_o  <= 1'b0;
      d_is_branch_o <= 1'b0;
      d_is_jal_o    <= 1'b0;
      d_is_jalr_o   <= 1'b0;
      d_is_system_o <= 1'b0;
      d_illegal_o   <= 1'b0;
    end else if (d_kill_i) begin
      d_valid_o <= 1'b0;
    end else if (!d_stall_i) begin
      if (hazard) begin
        d_valid_o <= 1'b0;
      end else begin
        d_valid_o     <= f_valid_i;
        d_ir_o        <= f_ir_i;
        d_pc_o        <= f_pc_i;
        d_pc_next_o   <= f_pc_next;
        d_opcode_o    <= f_ir_i[6:2];
        d_fun3_o      <= f_ir_i[14:12];
        d_fun7_o      <= f_ir_i[31:25];
        d_rs1_o       <= f_rs1;
        d_rs2_o       <= f_rs2;
        d_rd_o        <= f_rd;
        d_imm_o       <= f_imm;
        d_rd_we_o     <= f_rd_we;
        d_is_load_o   <= is_load;
        d_is_store_o  <= is_store;
        d_is_branch_o <= is_branch;
        d_is_jal_o    <= is_jal;
        d_is_jalr_o   <= is_jalr;
        d_is_system_o <= is_system;
        d_illegal_o   <= f_illegal;
      end
    end
  end

endmodule

// File: tb/tb_kamikaze_decode.sv
// Scoreboard bench for kamikaze_decode: directed vectors push hand-decoded
// expectations, a negedge monitor pops and compares the registered outputs.
module tb_kamikaze_decode;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        f_valid_i;
  logic [31:0] f_ir_i;
  logic [31:0] f_pc_i;
  logic        f_is_compressed_i;
  logic        f_stall_o;
  logic        d_stall_i;
  logic        d_kill_i;
  logic [4:0]  rf_rs1_o, rf_rs2_o;
  logic        d_valid_o;
  logic [31:0] d_ir_o, d_pc_o, d_pc_next_o, d_imm_o;
  logic [4:0]  d_opcode_o, d_rs1_o, d_rs2_o, d_rd_o;
  logic [2:0]  d_fun3_o;
  logic [6:0]  d_fun7_o;
  logic        d_rd_we_o, d_is_load_o, d_is_store_o, d_is_branch_o;
  logic        d_is_jal_o, d_is_jalr_o, d_is_system_o, d_illegal_o;

  typedef struct {
    int          due;
    logic        valid;
    logic [31:0] ir, pc, pcn, imm;
    logic [4:0]  opcode, rs1, rs2, rd;
    logic [2:0]  fun3;
    logic [6:0]  fun7;
    logic        we;
    logic [5:0]  flags;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;

  kamikaze_decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .f_valid_i(f_valid_i), .f_ir_i(f_ir_i), .f_pc_i(f_pc_i),
    .f_is_compressed_i(f_is_compressed_i), .f_stall_o(f_stall_o),
    .d_stall_i(d_stall_i), .d_kill_i(d_kill_i),
    .rf_rs1_o(rf_rs1_o), .rf_rs2_o(rf_rs2_o),
    .d_valid_o(d_valid_o), .d_ir_o(d_ir_o), .d_pc_o(d_pc_o),
    .d_pc_next_o(d_pc_next_o), .d_opcode_o(d_opcode_o), .d_fun3_o(d_fun3_o),
    .d_fun7_o(d_fun7_o), .d_rs1_o(d_rs1_o), .d_rs2_o(d_rs2_o), .d_rd_o(d_rd_o),
    .d_imm_o(d_imm_o), .d_rd_we_o(d_rd_we_o), .d_is_load_o(d_is_load_o),
    .d_is_store_o(d_is_store_o), .d_is_branch_o(d_is_branch_o),
    .d_is_jal_o(d_is_jal_o), .d_is_jalr_o(d_is_jalr_o),
    .d_is_system_o(d_is_system_o), .d_illegal_o(d_illegal_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [31:0] ir, pc, pcn,
                              input logic [4:0] opcode, input logic [2:0] fun3,
                              input logic [6:0] fun7, input logic [4:0] rs1, rs2, rd,
                              input logic [31:0] imm, input logic we,
                              input logic [5:0] flags, input logic illegal);
    exp_t e;
    e.due = 0; e.valid = v; e.ir = ir; e.pc = pc; e.pcn = pcn;
    e.opcode = opcode; e.fun3 = fun3; e.fun7 = fun7;
    e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.imm = imm;
    e.we = we; e.flags = flags; e.illegal = illegal;
    return e;
  endfunction

  // Monitor: compares every registered output against the entry due this cycle.
  always @(negedge clk_i) begin
    while (q.size() > 0 && q[0].due <= cycle) begin
      exp_t e;
      e = q.pop_front();
      check_output("d_valid", {31'd0, d_valid_o}, {31'd0, e.valid});
      if (e.valid) begin
        check_output("d_ir", d_ir_o, e.ir);
        check_output("d_pc", d_pc_o, e.pc);
        check_output("d_pc_next", d_pc_next_o, e.pcn);
        check_output("d_opcode", {27'd0, d_opcode_o}, {27'd0, e.opcode});
        check_output("d_fun3", {29'd0, d_fun3_o}, {29'd0, e.fun3});
        check_output("d_fun7", {25'd0, d_fun7_o}, {25'd0, e.fun7});
        check_output("d_rs1", {27'd0, d_rs1_o}, {27'd0, e.rs1});
        check_output("d_rs2", {27'd0, d_rs2_o}, {27'd0, e.rs2});
        check_output("d_rd", {27'd0, d_rd_o}, {27'd0, e.rd});
        check_output("d_imm", d_imm_o, e.imm);
        check_output("d_rd_we", {31'd0, d_rd_we_o}, {31'd0, e.we});
        check_output("d_flags", {26'd0, d_is_load_o, d_is_store_o, d_is_branch_o,
                                 d_is_jal_o, d_is_jalr_o, d_is_system_o},
                     {26'd0, e.flags});
        check_output("d_illegal", {31'd0, d_illegal_o}, {31'd0, e.illegal});
      end
    end
  end

  task automatic apply_stimulus(input logic v, input logic [31:0] ir, pc,
                                input logic comp, stall, kill,
                                input logic exp_fstall, input logic [4:0] exp_rf1, exp_rf2,
                                input logic do_push, input exp_t e);
    exp_t t;
    @(posedge clk_i);
    #1;
    f_valid_i = v; f_ir_i = ir; f_pc_i = pc; f_is_compressed_i = comp;
    d_stall_i = stall; d_kill_i = kill;
    if (do_push) begin
      t = e;
      t.due = cycle + 1;
      q.push_back(t);
    end
    @(negedge clk_i);
    check_output("f_stall", {31'd0, f_stall_o}, {31'd0, exp_fstall});
    check_output("rf_rs1", {27'd0, rf_rs1_o}, {27'd0, exp_rf1});
    check_output("rf_rs2", {27'd0, rf_rs2_o}, {27'd0, exp_rf2});
  endtask

  task automatic check_reset_state(input string tag);
    check_output({tag, " d_valid"}, {31'd0, d_valid_o}, 32'd0);
    check_output({tag, " d_pc"}, d_pc_o, 32'h0000_0000);
    check_output({tag, " d_pc_next"}, d_pc_next_o, 32'h0000_0004);
    check_output({tag, " d_ir"}, d_ir_o, 32'd0);
    check_output({tag, " d_imm"}, d_imm_o, 32'd0);
    check_output({tag, " d_rd_we"}, {31'd0, d_rd_we_o}, 32'd0);
    check_output({tag, " d_illegal"}, {31'd0, d_illegal_o}, 32'd0);
    check_output({tag, " d_rs1"}, {27'd0, d_rs1_o}, 32'd0);
  endtask

  initial begin
    exp_t bub, e_jal;
    bub   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_jal = mk(1, 32'hFFDFF0EF, 32'h30C, 32'h310, 5'b11011, 3'd7, 7'h7F,
               5'd31, 5'd29, 5'd1, 32'hFFFF_FFFC, 1, 6'b000100, 0);

    rst_i = 1'b0; f_valid_i = 0; f_ir_i = 0; f_pc_i = 0; f_is_compressed_i = 0;
    d_stall_i = 0; d_kill_i = 0;
    repeat (3) @(negedge clk_i);
    check_reset_state("reset");
    check_output("reset f_stall", {31'd0, f_stall_o}, 32'd0);
    rst_i = 1'b1;

    // ADDI x1,x2,-5 at 0x100
    apply_stimulus(1, 32'hFFB10093, 32'h100, 0, 0, 0, 0, 5'd2, 5'd27, 1,
      mk(1, 32'hFFB10093, 32'h100, 32'h104, 5'b00100, 3'd0, 7'h7F, 5'd2, 5'd27, 5'd1,
         32'hFFFF_FFFB, 1, 6'b0, 0));
    // LW x5,0(x6) then ADD x7,x5,x1: one bubble, ADD replayed
    apply_stimulus(1, 32'h00032283, 32'h104, 0, 0, 0, 0, 5'd6, 5'd0, 1,
      mk(1, 32'h00032283, 32'h104, 32'h108, 5'b00000, 3'd2, 7'd0, 5'd6, 5'd0, 5'd5,
         32'd0, 1, 6'b100000, 0));
    apply_stimulus(1, 32'h001283B3, 32'h108, 0, 0, 0, 1, 5'd6, 5'd0, 1, bub);
    apply_stimulus(1, 32'h001283B3, 32'h108, 0, 0, 0, 0, 5'd5, 5'd1, 1,
      mk(1, 32'h001283B3, 32'h108, 32'h10C, 5'b01100, 3'd0, 7'd0, 5'd5, 5'd1, 5'd7,
         32'd0, 1, 6'b0, 0));
    // Same pair with kill during the hazard cycle
    apply_stimulus(1, 32'h00032283, 32'h10C, 0, 0, 0, 0, 5'd6, 5'd0, 1,
      mk(1, 32'h00032283, 32'h10C, 32'h110, 5'b00000, 3'd2, 7'd0, 5'd6, 5'd0, 5'd5,
         32'd0, 1, 6'b100000, 0));
    apply_stimulus(1, 32'h001283B3, 32'h110, 0, 0, 1, 0, 5'd6, 5'd0, 1, bub);
    apply_stimulus(1, 32'h001283B3, 32'h110, 0, 0, 0, 0, 5'd5, 5'd1, 1,
      mk(1, 32'h001283B3, 32'h110, 32'h114, 5'b01100, 3'd0, 7'd0, 5'd5, 5'd1, 5'd7,
         32'd0, 1, 6'b0, 0));
    // Compressed PC increments, including 32-bit wrap
    apply_stimulus(1, 32'hFFB10093, 32'h200, 1, 0, 0, 0, 5'd2, 5'd27, 1,
      mk(1, 32'hFFB10093, 32'h200, 32'h202, 5'b00100, 3'd0, 7'h7F, 5'd2, 5'd27, 5'd1,
         32'hFFFF_FFFB, 1, 6'b0, 0));
    apply_stimulus(1, 32'hFFB10093, 32'hFFFF_FFFE, 1, 0, 0, 0, 5'd2, 5'd27, 1,
      mk(1, 32'hFFB10093, 32'hFFFF_FFFE, 32'h0, 5'b00100, 3'd0, 7'h7F, 5'd2, 5'd27, 5'd1,
         32'hFFFF_FFFB, 1, 6'b0, 0));
    // All-zero word is illegal but still valid
    apply_stimulus(1, 32'h0, 32'h300, 0, 0, 0, 0, 5'd0, 5'd0, 1,
      mk(1, 32'h0, 32'h300, 32'h304, 5'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0,
         32'd0, 0, 6'b0, 1));
    // SW x5,8(x6); BEQ x1,x2,-8; JAL x1,-4
    apply_stimulus(1, 32'h00532423, 32'h304, 0, 0, 0, 0, 5'd6, 5'd5, 1,
      mk(1, 32'h00532423, 32'h304, 32'h308, 5'b01000, 3'd2, 7'd0, 5'd6, 5'd5, 5'd8,
         32'd8, 0, 6'b010000, 0));
    apply_stimulus(1, 32'hFE208CE3, 32'h308, 0, 0, 0, 0, 5'd1, 5'd2, 1,
      mk(1, 32'hFE208CE3, 32'h308, 32'h30C, 5'b11000, 3'd0, 7'h7F, 5'd1, 5'd2, 5'd25,
         32'hFFFF_FFF8, 0, 6'b001000, 0));
    apply_stimulus(1, 32'hFFDFF0EF, 32'h30C, 0, 0, 0, 0, 5'd31, 5'd29, 1, e_jal);
    // Three stall cycles with changing fetch inputs: JAL stays frozen
    apply_stimulus(1, 32'h00032283, 32'h500, 0, 1, 0, 1, 5'd31, 5'd29, 1, e_jal);
    apply_stimulus(1, 32'h001283B3, 32'h504, 1, 1, 0, 1, 5'd31, 5'd29, 1, e_jal);
    apply_stimulus(1, 32'hFFB10093, 32'h508, 0, 1, 0, 1, 5'd31, 5'd29, 1, e_jal);
    // Reset asserted in the middle of a stalled cycle
    @(posedge clk_i);
    #1;
    f_ir_i = 32'h00532423; f_pc_i = 32'h50C;
    @(negedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    check_reset_state("midstall reset");
    d_stall_i = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    // Recovery after reset
    apply_stimulus(1, 32'hFFB10093, 32'h400, 0, 0, 0, 0, 5'd2, 5'd27, 1,
      mk(1, 32'hFFB10093, 32'h400, 32'h404, 5'b00100, 3'd0, 7'h7F, 5'd2, 5'd27, 5'd1,
         32'hFFFF_FFFB, 1, 6'b0, 0));
    apply_stimulus(0, 32'h0, 32'h404, 0, 0, 0, 0, 5'd0, 5'd0, 1, bub);
    repeat (2) @(negedge clk_i);
    check_output("scoreboard drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
